// File: rtl/dual_lane_deserializer.sv
// Two-bit-lane framed symbol receiver: start/data/stop framing, WIDTH-bit word
// assembly, and a DEPTH-entry show-ahead FIFO with framing-error and overflow flags.
module dual_lane_deserializer #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [1:0]                 rx_i,
  input  logic                       rx_en_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       frame_err_o,
  output logic                       overflow_o,
  input  logic                       clr_i
);

  localparam int SYMS  = WIDTH / 2;
  localparam int CNT_W = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  localparam logic [1:0] SYM_START = 2'b00;
  localparam logic [1:0] SYM_STOP  = 2'b11;

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
      $error("dual_lane_deserializer: WIDTH must be even and >= 2");
    end
    if (DEPTH < 2) begin : g_bad_depth
      $error("dual_lane_deserializer: DEPTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sreg;
  logic             push;
  logic             frame_err_nxt;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic             ovf_set;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Framing FSM: every transition is qualified by the symbol strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    push          = 1'b0;
    frame_err_nxt = 1'b0;
    if (rx_en_i) begin
      case (state)
        ST_IDLE: if (rx_i == SYM_START) state_nxt = ST_DATA;
        ST_DATA: if (cnt == CNT_LAST) state_nxt = ST_STOP;
        ST_STOP: begin
          // A bad stop never doubles as a new start; the line must go idle first
          state_nxt = ST_IDLE;
          if (rx_i == SYM_STOP) push = 1'b1;
          else                  frame_err_nxt = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Symbol k of a frame lands in bits [2k+1:2k]
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt  <= '0;
      sreg <= '0;
    end else if (rx_en_i) begin
      if (state == ST_IDLE) begin
        cnt <= '0;
      end else if (state == ST_DATA) begin
        sreg[{cnt, 1'b0} +: 2] <= rx_i;
        if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
      end
    end
  end

  // FIFO: a push into a full FIFO is still accepted when the head leaves this cycle
  assign pop     = valid_o & ready_i;
  assign full    = (level == LVL_FULL);
  assign push_ok = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= sreg;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      frame_err_o <= frame_err_nxt;
      // A fresh overflow outranks a same-cycle clear
      if (ovf_set)    overflow_o <= 1'b1;
      else if (clr_i) overflow_o <= 1'b0;
    end
  end

  assign valid_o = (level != '0);
  assign level_o = level;
  assign data_o  = valid_o ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_dual_lane_deserializer.sv
// Directed bench for dual_lane_deserializer (WIDTH=12, DEPTH=4) with
// hand-computed expectations and immediate-assertion checks.
module tb_dual_lane_deserializer;

  logic        clk;
  logic        rst;
  logic [1:0]  rx;
  logic        rx_en;
  logic [11:0] data;
  logic        valid;
  logic        ready;
  logic [2:0]  level;
  logic        frame_err;
  logic        overflow;
  logic        clr;

  int checks   = 0;
  int failures = 0;

  dual_lane_deserializer #(.WIDTH(12), .DEPTH(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .rx_en_i     (rx_en),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .level_o     (level),
    .frame_err_o (frame_err),
    .overflow_o  (overflow),
    .clr_i       (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sym(input logic [1:0] s);
    rx    = s;
    rx_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [11:0] w, input logic [1:0] stop, input logic rdy_on_stop);
    sym(2'b00);
    for (int k = 0; k < 6; k++) sym(w[2*k +: 2]);
    if (rdy_on_stop) ready = 1'b1;
    sym(stop);
    ready = 1'b0;
    rx    = 2'b11;
  endtask

  task automatic pop_one();
    rx    = 2'b11;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  initial begin
    logic [11:0] w;
    rst   = 1'b1;
    rx    = 2'b11;
    rx_en = 1'b0;
    ready = 1'b0;
    clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: basic frame
    sym(2'b00); sym(2'b00); sym(2'b11); sym(2'b01);
    sym(2'b01); sym(2'b10); sym(2'b10);
    check("t1_pre_stop_valid", 32'(valid), 32'h0);
    sym(2'b11);
    check("t1_valid", 32'(valid), 32'h1);
    check("t1_data", 32'(data), 32'hA5C);
    check("t1_level", 32'(level), 32'h1);
    pop_one();
    check("t1_drained_level", 32'(level), 32'h0);
    check("t1_drained_data", 32'(data), 32'h0);

    // 2: same frame with strobe gaps carrying garbage 00 symbols
    w = 12'hA5C;
    for (int k = 0; k < 7; k++) begin
      rx = 2'b00; rx_en = 1'b0;
      @(posedge clk); #1;
      sym((k == 0) ? 2'b00 : w[2*(k-1) +: 2]);
    end
    rx = 2'b00; rx_en = 1'b0;
    @(posedge clk); #1;
    check("t2_gap_valid", 32'(valid), 32'h0);
    sym(2'b11);
    check("t2_valid", 32'(valid), 32'h1);
    check("t2_data", 32'(data), 32'hA5C);
    check("t2_level", 32'(level), 32'h1);

    // 3: bad stop symbol, then a good frame
    send_frame(12'h123, 2'b01, 1'b0);
    check("t3_ferr_hi", 32'(frame_err), 32'h1);
    check("t3_level_kept", 32'(level), 32'h1);
    sym(2'b11);
    check("t3_ferr_lo", 32'(frame_err), 32'h0);
    send_frame(12'h3C9, 2'b11, 1'b0);
    check("t3_level_after", 32'(level), 32'h2);
    check("t3_head", 32'(data), 32'hA5C);
    pop_one();
    check("t3_second", 32'(data), 32'h3C9);
    pop_one();
    check("t3_empty", 32'(valid), 32'h0);

    // 4: overflow with ready low
    for (int i = 1; i <= 4; i++) send_frame(12'(i), 2'b11, 1'b0);
    check("t4_level4", 32'(level), 32'h4);
    check("t4_no_ovf_yet", 32'(overflow), 32'h0);
    send_frame(12'h005, 2'b11, 1'b0);
    check("t4_ovf", 32'(overflow), 32'h1);
    check("t4_level_full", 32'(level), 32'h4);
    for (int i = 1; i <= 4; i++) begin
      check("t4_drain", 32'(data), 32'(i));
      pop_one();
    end
    check("t4_drained_valid", 32'(valid), 32'h0);
    check("t4_drained_data", 32'(data), 32'h0);
    check("t4_ovf_sticky", 32'(overflow), 32'h1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("t4_clr", 32'(overflow), 32'h0);

    // 5: full FIFO with a pop on the stop cycle
    for (int i = 1; i <= 4; i++) send_frame(12'h010 + 12'(i), 2'b11, 1'b0);
    send_frame(12'h015, 2'b11, 1'b1);
    check("t5_no_ovf", 32'(overflow), 32'h0);
    check("t5_level", 32'(level), 32'h4);
    for (int i = 2; i <= 5; i++) begin
      check("t5_drain", 32'(data), 32'h010 + 32'(i));
      pop_one();
    end
    check("t5_empty", 32'(level), 32'h0);

    // 6: reset mid-frame with two words queued
    send_frame(12'h0AA, 2'b11, 1'b0);
    send_frame(12'h055, 2'b11, 1'b0);
    check("t6_level2", 32'(level), 32'h2);
    sym(2'b00); sym(2'b10); sym(2'b11);
    rst = 1'b1;
    #2;
    check("t6_rst_valid", 32'(valid), 32'h0);
    check("t6_rst_level", 32'(level), 32'h0);
    check("t6_rst_data", 32'(data), 32'h0);
    rst = 1'b0;
    sym(2'b10); sym(2'b10); sym(2'b11); sym(2'b11); sym(2'b11);
    check("t6_tail_no_word", 32'(valid), 32'h0);
    send_frame(12'h2B7, 2'b11, 1'b0);
    check("t6_new_level", 32'(level), 32'h1);
    check("t6_new_data", 32'(data), 32'h2B7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
